// File: rtl/mem_pkg.sv
// Shared constants and types for the main-memory responder and the cache side
// that talks to it.
package mem_pkg;

    localparam int WORD_W      = 32;
    localparam int BLOCK_WORDS = 32;

    localparam int INIT_ZERO = 0;
    localparam int INIT_ADDR = 1;

    typedef enum logic {MEM_INIT, MEM_READY} mem_state_t;

endpackage

// File: rtl/mem_lat_pipe.sv
// Fixed-latency valid+data delay line for read responses; each data stage only
// loads alongside a valid word, so the tail holds the last returned value.
module mem_lat_pipe #(
    parameter int LAT = 2,
    parameter int W   = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    output logic [W-1:0] out_data
);

    logic [LAT-1:0] valid_q;
    logic [W-1:0]   data_q [LAT];

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            for (int i = 0; i < LAT; i++) begin
                data_q[i] <= '0;
            end
        end else begin
            valid_q[0] <= in_valid;
            if (in_valid) begin
                data_q[0] <= in_data;
            end
            for (int i = 1; i < LAT; i++) begin
                valid_q[i] <= valid_q[i-1];
                if (valid_q[i-1]) begin
                    data_q[i] <= data_q[i-1];
                end
            end
        end
    end

    assign out_valid = valid_q[LAT-1];
    assign out_data  = data_q[LAT-1];

endmodule

// File: rtl/mem_responder.sv
// Memory-side end of the cache miss/writeback interface: word RAM with a
// post-reset init sweep and a pipelined fixed-latency read path.
module mem_responder
    import mem_pkg::*;
#(
    parameter int DEPTH     = 4096,
    parameter int READ_LAT  = 2,
    parameter int INIT_MODE = INIT_ADDR
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_ren,
    input  logic              mem_wen,
    input  logic [31:0]       mem_addr,
    input  logic [WORD_W-1:0] mem_din,
    output logic [WORD_W-1:0] mem_dout,
    output logic              mem_rvalid,
    output logic              mem_init_done
);

    localparam int AW = $clog2(DEPTH);

    logic [WORD_W-1:0] ram [DEPTH];
    mem_state_t        state;
    logic [AW-1:0]     init_ctr;
    logic [AW-1:0]     idx;
    logic [WORD_W-1:0] init_word;
    logic [WORD_W-1:0] rd_word;
    logic              rd_fire;
    logic              unused_addr_bits;

    // Byte offset and bits above the index are dropped, so addresses wrap.
    assign idx              = mem_addr[AW+1:2];
    assign unused_addr_bits = ^{mem_addr[31:AW+2], mem_addr[1:0]};

    assign init_word = (INIT_MODE == INIT_ADDR) ? (WORD_W'(init_ctr) << 2) : '0;
    assign rd_fire   = (state == MEM_READY) && mem_ren;

    // Only one address bus exists, so a same-cycle write always hits the read word.
    assign rd_word = mem_wen ? mem_din : ram[idx];

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= MEM_INIT;
            init_ctr <= '0;
        end else if (state == MEM_INIT) begin
            init_ctr <= init_ctr + 1'b1;
            if (init_ctr == AW'(DEPTH - 1)) begin
                state <= MEM_READY;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state == MEM_INIT) begin
                ram[init_ctr] <= init_word;
            end else if (mem_wen) begin
                ram[idx] <= mem_din;
            end
        end
    end

    mem_lat_pipe #(
        .LAT (READ_LAT),
        .W   (WORD_W)
    ) u_lat_pipe (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (rd_fire),
        .in_data   (rd_word),
        .out_valid (mem_rvalid),
        .out_data  (mem_dout)
    );

    assign mem_init_done = (state == MEM_READY);

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: a cycle-level reference model plus
// table-driven vectors and hand-written sequences for the multi-cycle cases.
module tb_mem_responder;
    import mem_pkg::*;

    localparam int DEPTH    = 4096;
    localparam int READ_LAT = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_ren;
    logic        mem_wen;
    logic [31:0] mem_addr;
    logic [31:0] mem_din;
    logic [31:0] mem_dout;
    logic        mem_rvalid;
    logic        mem_init_done;

    always #5 clk = ~clk;

    mem_responder #(
        .DEPTH     (DEPTH),
        .READ_LAT  (READ_LAT),
        .INIT_MODE (INIT_ADDR)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .mem_ren       (mem_ren),
        .mem_wen       (mem_wen),
        .mem_addr      (mem_addr),
        .mem_din       (mem_din),
        .mem_dout      (mem_dout),
        .mem_rvalid    (mem_rvalid),
        .mem_init_done (mem_init_done)
    );

    // Reference model: word array, edge count since reset, and a queue of
    // responses each tagged with the cycle in which it must appear.
    typedef struct {
        int          due;
        logic [31:0] data;
    } resp_t;

    resp_t       pending[$];
    logic [31:0] model_mem [DEPTH];
    int          cyc = 0;
    int          since_reset = 0;
    logic [31:0] exp_dout = '0;
    int          checks = 0;
    int          passes = 0;

    typedef struct {
        logic        wen;
        logic        ren;
        logic [31:0] addr;
        logic [31:0] din;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[9];

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    endfunction

    task automatic modelEdge(input logic r, input logic rn, input logic wn,
                             input logic [31:0] a, input logic [31:0] d);
        int    w;
        resp_t resp;
        cyc++;
        if (r) begin
            since_reset = 0;
            pending.delete();
            exp_dout = '0;
            for (int i = 0; i < DEPTH; i++) model_mem[i] = 32'(i * 4);
            return;
        end
        w = int'((a >> 2) % 32'(DEPTH));
        if (since_reset >= DEPTH) begin
            if (rn) begin
                resp.due  = cyc + READ_LAT - 1;
                resp.data = wn ? d : model_mem[w];
                pending.push_back(resp);
            end
            if (wn) model_mem[w] = d;
        end
        since_reset++;
    endtask

    task automatic checkOutput();
        logic  exp_valid;
        resp_t head;
        exp_valid = 1'b0;
        if (pending.size() > 0 && pending[0].due == cyc) begin
            exp_valid = 1'b1;
            head      = pending.pop_front();
            exp_dout  = head.data;
        end
        check("rvalid", 32'(mem_rvalid), 32'(exp_valid));
        check("dout", mem_dout, exp_dout);
        check("init_done", 32'(mem_init_done), 32'(since_reset >= DEPTH));
    endtask

    task automatic applyStimulus(input logic r, input logic rn, input logic wn,
                                 input logic [31:0] a, input logic [31:0] d);
        rst      = r;
        mem_ren  = rn;
        mem_wen  = wn;
        mem_addr = a;
        mem_din  = d;
        @(posedge clk);
        modelEdge(r, rn, wn, a, d);
        #1;
        checkOutput();
    endtask

    task automatic idle();
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    task automatic waitResp(output logic got, output int lat, output logic [31:0] data);
        got  = 1'b0;
        lat  = -1;
        data = '0;
        for (int k = 0; k < 20; k++) begin
            if (mem_rvalid) begin
                got  = 1'b1;
                lat  = k;
                data = mem_dout;
                return;
            end
            idle();
        end
    endtask

    // Counts cycles since rst deasserted until init_done, pulsing ren mid-sweep.
    task automatic runInit(input int already);
        int n;
        n = already;
        while (!mem_init_done && n < DEPTH + 100) begin
            applyStimulus(1'b0, (n >= 100 && n < 104), 1'b0, 32'h10, 32'h0);
            n++;
        end
        check("init_cycles", 32'(n), 32'(DEPTH));
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic        got;
        int          lat;
        logic [31:0] data;
        int          nvalid;
        int          first;
        int          last;
        logic [31:0] a;

        vecs[0] = '{1'b1, 1'b0, 32'h0000_1000, 32'hDEAD_BEEF, 32'h0};
        vecs[1] = '{1'b0, 1'b1, 32'h0000_1000, 32'h0,         32'hDEAD_BEEF};
        vecs[2] = '{1'b0, 1'b1, 32'h0000_5000, 32'h0,         32'hDEAD_BEEF};
        vecs[3] = '{1'b1, 1'b1, 32'h0000_0008, 32'hACE1_2000, 32'hACE1_2000};
        vecs[4] = '{1'b0, 1'b1, 32'h0000_0003, 32'h0,         32'h0000_0000};
        vecs[5] = '{1'b0, 1'b1, 32'h0000_3FFE, 32'h0,         32'h0000_3FFC};
        vecs[6] = '{1'b0, 1'b1, 32'hFFFF_4004, 32'h0,         32'h0000_0004};
        vecs[7] = '{1'b1, 1'b0, 32'h0000_7FFC, 32'hCAFE_F00D, 32'h0};
        vecs[8] = '{1'b0, 1'b1, 32'h0000_3FFC, 32'h0,         32'hCAFE_F00D};

        $display("[TB] reset and init sweep");
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        runInit(0);

        $display("[TB] single read with hold");
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0000_000C, 32'h0);
        waitResp(got, lat, data);
        check("single_seen", 32'(got), 32'd1);
        check("single_lat", 32'(lat), 32'(READ_LAT - 1));
        check("single_data", data, 32'h0000_000C);
        for (int k = 0; k < 5; k++) begin
            idle();
            check("hold_dout", mem_dout, 32'h0000_000C);
            check("hold_rvalid", 32'(mem_rvalid), 32'd0);
        end

        $display("[TB] read-then-write same word");
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0000_0008, 32'h0);
        applyStimulus(1'b0, 1'b0, 1'b1, 32'h0000_0008, 32'h1111_1111);
        waitResp(got, lat, data);
        check("rdwr_seen", 32'(got), 32'd1);
        check("rdwr_lat", 32'(lat), 32'(READ_LAT - 2));
        check("rdwr_data", data, 32'h0000_0008);

        $display("[TB] vector table");
        for (int i = 0; i < 9; i++) begin
            applyStimulus(1'b0, vecs[i].ren, vecs[i].wen, vecs[i].addr, vecs[i].din);
            if (vecs[i].ren) begin
                waitResp(got, lat, data);
                check($sformatf("vec%0d_seen", i), 32'(got), 32'd1);
                check($sformatf("vec%0d_lat", i), 32'(lat), 32'(READ_LAT - 1));
                check($sformatf("vec%0d_data", i), data, vecs[i].exp);
            end
        end

        $display("[TB] 32-word burst");
        nvalid = 0;
        first  = 0;
        last   = 0;
        for (int k = 1; k <= 40; k++) begin
            applyStimulus(1'b0, (k <= 32), 1'b0, 32'h0000_2000 + 32'(4 * (k - 1)), 32'h0);
            if (mem_rvalid) begin
                check("burst_data", mem_dout, 32'h0000_2000 + 32'(4 * nvalid));
                if (nvalid == 0) first = k;
                nvalid++;
                last = k;
            end
        end
        check("burst_count", 32'(nvalid), 32'd32);
        check("burst_first_cycle", 32'(first + 1), 32'(1 + READ_LAT));
        check("burst_last_cycle", 32'(last + 1), 32'(32 + READ_LAT));

        $display("[TB] random traffic");
        for (int k = 0; k < 400; k++) begin
            a = ($urandom & 32'hFFFF_C000) | (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
            applyStimulus(1'b0, 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0), a, $urandom);
        end
        for (int k = 0; k < 4; k++) idle();

        $display("[TB] reset mid-burst");
        for (int k = 1; k <= 10; k++) begin
            applyStimulus((k == 4), 1'b1, (k == 4), 32'h0000_3000 + 32'(4 * (k - 1)), 32'h5555_5555);
            if (k >= 4) begin
                check("rstburst_rvalid", 32'(mem_rvalid), 32'd0);
                check("rstburst_init_done", 32'(mem_init_done), 32'd0);
            end
        end
        runInit(6);
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0000_3000, 32'h0);
        waitResp(got, lat, data);
        check("post_rst_seen", 32'(got), 32'd1);
        check("post_rst_data", data, 32'h0000_3000);
        for (int k = 0; k < 3; k++) idle();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
